// File: rtl/nx_msg_distributor_pkg.sv
// Shared Nexus constants: message layout, column field width and broadcast column value.
// NX_DISTRIBUTOR_BROADCAST_EN (optional) makes the all-ones column a broadcast.
package NXConstants;

   localparam int ROW_WIDTH     = 3;
   localparam int COLUMN_WIDTH  = 3;
   localparam int COMMAND_WIDTH = 2;
   localparam int PAYLOAD_WIDTH = 24;

   typedef struct packed {
      logic [ROW_WIDTH-1:0]     row;
      logic [COLUMN_WIDTH-1:0]  column;
      logic [COMMAND_WIDTH-1:0] command;
   } node_header_t;

   typedef struct packed {
      node_header_t             header;
      logic [PAYLOAD_WIDTH-1:0] payload;
   } node_message_t;

   localparam int MESSAGE_WIDTH = $bits(node_message_t);

   localparam logic [COLUMN_WIDTH-1:0] COLUMN_BROADCAST = {COLUMN_WIDTH{1'b1}};

   function automatic logic is_broadcast(input logic [COLUMN_WIDTH-1:0] column);
      return column == COLUMN_BROADCAST;
   endfunction

endpackage

// File: rtl/nx_msg_distributor_if.sv
// Bus bundle for the message distributor: one inbound stream, OUTPUTS outbound column streams.
// The slave modport is the distributor side, the master modport the producer/consumer side.
interface nx_msg_distributor_if #(
   parameter int OUTPUTS = 4
);
   import NXConstants::*;

   node_message_t                 i_ib_data;
   logic                          i_ib_valid;
   logic                          o_ib_ready;
   node_message_t [OUTPUTS-1:0]   o_ob_data;
   logic [OUTPUTS-1:0]            o_ob_valid;
   logic [OUTPUTS-1:0]            i_ob_ready;
   logic [7:0]                    o_drop_count;
   logic                          o_idle;

   modport slave (
      input  i_ib_data, i_ib_valid, i_ob_ready,
      output o_ib_ready, o_ob_data, o_ob_valid, o_drop_count, o_idle
   );

   modport master (
      output i_ib_data, i_ib_valid, i_ob_ready,
      input  o_ib_ready, o_ob_data, o_ob_valid, o_drop_count, o_idle
   );

endinterface

// File: rtl/nx_msg_distributor_fifo.sv
// nx_fifo: synchronous FIFO with registered occupancy; full is registered so a pop does not
// free a slot for a push in the same cycle. Output holds the last popped word when empty.
module nx_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_empty,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] last_r;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
   endfunction

   assign o_full    = (count_r == CNT_W'(DEPTH));
   assign o_empty   = (count_r == {CNT_W{1'b0}});
   assign o_valid   = !o_empty;
   assign o_data    = o_empty ? last_r : mem_r[rd_ptr_r];
   assign do_push_s = i_push && !o_full;
   assign do_pop_s  = i_pop && !o_empty;

   // Storage array: datapath only, never reset.
   always_ff @(posedge i_clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= i_data;
      end
   end

   // Pointers, occupancy and held output word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         last_r   <= {WIDTH{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
            last_r   <= mem_r[rd_ptr_r];
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/nx_msg_distributor.sv
// Routes inbound Nexus messages to per-column FIFOs by header column; unroutable columns are
// dropped and counted. Optional macro NX_DISTRIBUTOR_BROADCAST_EN enables all-ones broadcast.
module nx_msg_distributor
   import NXConstants::*;
#(
   parameter int OUTPUTS    = 4,
   parameter int FIFO_DEPTH = 2
) (
   input logic                   i_clk,
   input logic                   i_rst,
   nx_msg_distributor_if.slave   bus
);

   localparam int SEL_W = $clog2(OUTPUTS);

   logic [31:0]                  col_ext_s;
   logic [SEL_W-1:0]             tgt_s;
   logic                         is_bcast_s;
   logic                         is_drop_s;
   logic                         ib_ready_s;
   logic [OUTPUTS-1:0]           full_s;
   logic [OUTPUTS-1:0]           empty_s;
   logic [OUTPUTS-1:0]           push_s;
   logic [OUTPUTS-1:0]           pop_s;
   logic [OUTPUTS-1:0]           valid_s;
   node_message_t [OUTPUTS-1:0]  data_s;
   logic [7:0]                   drop_count_r;

   // Column decode and acceptance; readiness never looks at i_ib_valid.
   always_comb begin
      col_ext_s  = 32'(bus.i_ib_data.header.column);
      tgt_s      = col_ext_s[SEL_W-1:0];
`ifdef NX_DISTRIBUTOR_BROADCAST_EN
      is_bcast_s = is_broadcast(bus.i_ib_data.header.column);
`else
      is_bcast_s = 1'b0;
`endif
      is_drop_s  = !is_bcast_s && (col_ext_s >= 32'(OUTPUTS));
      if (is_bcast_s) begin
         ib_ready_s = ~|full_s;
      end else if (is_drop_s) begin
         ib_ready_s = 1'b1;
      end else begin
         ib_ready_s = !full_s[tgt_s];
      end
   end

   // Per-column push/pop strobes.
   always_comb begin
      push_s = {OUTPUTS{1'b0}};
      pop_s  = {OUTPUTS{1'b0}};
      for (int c = 0; c < OUTPUTS; c++) begin
         if (bus.i_ib_valid && ib_ready_s && !is_drop_s &&
             (is_bcast_s || (tgt_s == SEL_W'(c)))) begin
            push_s[c] = 1'b1;
         end else begin
            push_s[c] = 1'b0;
         end
         pop_s[c] = valid_s[c] && bus.i_ob_ready[c];
      end
   end

   for (genvar c = 0; c < OUTPUTS; c++) begin : g_col
      nx_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (MESSAGE_WIDTH)
      ) u_fifo (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_push  (push_s[c]),
         .i_data  (bus.i_ib_data),
         .o_full  (full_s[c]),
         .o_empty (empty_s[c]),
         .i_pop   (pop_s[c]),
         .o_valid (valid_s[c]),
         .o_data  (data_s[c])
      );
   end

   // Saturating count of dropped messages.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         drop_count_r <= 8'd0;
      end else if (bus.i_ib_valid && is_drop_s && (drop_count_r != 8'hFF)) begin
         drop_count_r <= drop_count_r + 8'd1;
      end else begin
         drop_count_r <= drop_count_r;
      end
   end

   assign bus.o_ib_ready   = ib_ready_s;
   assign bus.o_ob_data    = data_s;
   assign bus.o_ob_valid   = valid_s;
   assign bus.o_drop_count = drop_count_r;
   assign bus.o_idle       = &empty_s;

endmodule

// File: tb/tb_nx_msg_distributor.sv
// Scoreboard bench for nx_msg_distributor (OUTPUTS=4, FIFO_DEPTH=2); per-column expected queues
// are filled on acceptance and drained by a negedge monitor on every outbound handshake.
module tb_nx_msg_distributor;
   import NXConstants::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   base_drops;
   node_message_t exp_q[4][$];

   nx_msg_distributor_if #(.OUTPUTS(4)) bus();

   nx_msg_distributor #(
      .OUTPUTS    (4),
      .FIFO_DEPTH (2)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic node_message_t mk(input logic [2:0] col, input logic [23:0] pl);
      node_message_t m;
      m.header.row     = 3'd1;
      m.header.column  = col;
      m.header.command = 2'd2;
      m.payload        = pl;
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input node_message_t m, input int dest);
      if (dest == 99) begin
         for (int c = 0; c < 4; c++) exp_q[c].push_back(m);
      end else if (dest >= 0) begin
         exp_q[dest].push_back(m);
      end
   endtask

   // Drives one message starting just after a posedge, returns just after the accepting posedge.
   task automatic send(input node_message_t m, input int dest);
      bit acc;
      acc = 1'b0;
      bus.i_ib_data  = m;
      bus.i_ib_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         if (bus.o_ib_ready) begin
            acc = 1'b1;
            push_exp(m, dest);
         end
         @(posedge clk); #1;
      end
      bus.i_ib_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: payload %0h never accepted", m.payload);
      end
   endtask

   // Monitor: every outbound handshake must match the head of its column queue.
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (!rst && bus.o_ob_valid[c] && bus.i_ob_ready[c]) begin
            checks++;
            if (exp_q[c].size() == 0) begin
               errors++;
               $display("FAIL unexpected_out col%0d: got %0h expected nothing", c, bus.o_ob_data[c]);
            end else begin
               node_message_t e;
               e = exp_q[c].pop_front();
               if (bus.o_ob_data[c] !== e) begin
                  errors++;
                  $display("FAIL data col%0d: got %0h expected %0h", c, bus.o_ob_data[c], e);
               end
            end
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus.i_ib_data  = '0;
      bus.i_ib_valid = 1'b0;
      bus.i_ob_ready = 4'b1111;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(bus.o_ob_valid), 32'h0);
      check("rst_idle", 32'(bus.o_idle), 32'h1);
      check("rst_drop", 32'(bus.o_drop_count), 32'h0);
      check("rst_ready", 32'(bus.o_ib_ready), 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single message to column 2, valid exactly one cycle after acceptance.
      send(mk(3'd2, 24'hA5C3E1), 2);
      @(negedge clk);
      check("single_valid", 32'(bus.o_ob_valid), 32'h4);
      check("single_busy", 32'(bus.o_idle), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("single_gone", 32'(bus.o_ob_valid), 32'h0);
      check("single_idle", 32'(bus.o_idle), 32'h1);
      @(posedge clk); #1;

      // Column 1 stalled: head-of-line blocking, column 0 still drains.
      bus.i_ob_ready = 4'b1101;
      send(mk(3'd0, 24'h000010), 0);
      send(mk(3'd1, 24'h000011), 1);
      send(mk(3'd1, 24'h000012), 1);
      bus.i_ib_data  = mk(3'd1, 24'h000013);
      bus.i_ib_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hol_block", 32'(bus.o_ib_ready), 32'h0);
         check("col3_empty", 32'(bus.o_ob_valid[3]), 32'h0);
         check("col0_drained", 32'(bus.o_ob_valid[0]), 32'h0);
         @(posedge clk); #1;
      end
      bus.i_ob_ready = 4'b1111;
      send(mk(3'd1, 24'h000013), 1);
      send(mk(3'd3, 24'h000014), 3);
      repeat (4) @(posedge clk);
      #1;

      // Full column 0: pop and push offered together, push waits one cycle.
      bus.i_ob_ready = 4'b1110;
      send(mk(3'd0, 24'h0000A1), 0);
      send(mk(3'd0, 24'h0000A2), 0);
      bus.i_ib_data  = mk(3'd0, 24'h0000A3);
      bus.i_ib_valid = 1'b1;
      bus.i_ob_ready = 4'b1111;
      @(negedge clk);
      check("full_pop_push_refused", 32'(bus.o_ib_ready), 32'h0);
      @(posedge clk); #1;
      bus.i_ob_ready = 4'b1110;
      @(negedge clk);
      check("push_next_cycle", 32'(bus.o_ib_ready), 32'h1);
      if (bus.o_ib_ready) push_exp(bus.i_ib_data, 0);
      @(posedge clk); #1;
      bus.i_ib_valid = 1'b0;
      bus.i_ob_ready = 4'b1111;
      repeat (4) @(posedge clk);
      #1;

`ifdef NX_DISTRIBUTOR_BROADCAST_EN
      // Broadcast blocked by full column 2, then fans out to every column at once.
      bus.i_ob_ready = 4'b1011;
      send(mk(3'd2, 24'h0000B1), 2);
      send(mk(3'd2, 24'h0000B2), 2);
      bus.i_ib_data  = mk(3'd7, 24'h0000BB);
      bus.i_ib_valid = 1'b1;
      @(negedge clk);
      check("bcast_blocked", 32'(bus.o_ib_ready), 32'h0);
      @(posedge clk); #1;
      bus.i_ob_ready = 4'b1111;
      @(negedge clk);
      check("bcast_blocked_pop", 32'(bus.o_ib_ready), 32'h0);
      @(posedge clk); #1;
      bus.i_ob_ready = 4'b1011;
      @(negedge clk);
      check("bcast_accept", 32'(bus.o_ib_ready), 32'h1);
      if (bus.o_ib_ready) push_exp(bus.i_ib_data, 99);
      @(posedge clk); #1;
      bus.i_ib_valid = 1'b0;
      @(negedge clk);
      check("bcast_all_valid", 32'(bus.o_ob_valid), 32'hF);
      @(posedge clk); #1;
      bus.i_ob_ready = 4'b1111;
      repeat (4) @(posedge clk);
      #1;
      base_drops = 0;
`else
      // All-ones column is ordinary: 7 >= OUTPUTS, so it is dropped.
      send(mk(3'd7, 24'h0000C7), -1);
      @(negedge clk);
      check("allones_dropped", 32'(bus.o_drop_count), 32'h1);
      @(posedge clk); #1;
      base_drops = 1;
`endif

      // 300 unroutable messages: always ready, counter saturates.
      bus.i_ib_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         bus.i_ib_data = mk(3'd5, 24'(i));
         @(negedge clk);
         if (!bus.o_ib_ready) begin
            check("drop_ready", 32'(bus.o_ib_ready), 32'h1);
         end
         if (i == 200) check("drop_mid", 32'(bus.o_drop_count), 32'(200 + base_drops));
         @(posedge clk); #1;
      end
      bus.i_ib_valid = 1'b0;
      @(negedge clk);
      check("drop_sat", 32'(bus.o_drop_count), 32'hFF);
      check("drop_no_out", 32'(bus.o_ob_valid), 32'h0);
      @(posedge clk); #1;

      // Two messages per column, then an asynchronous mid-cycle reset.
      bus.i_ob_ready = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         send(mk(3'(c), 24'(16'hD000 + c)), -1);
         send(mk(3'(c), 24'(16'hD100 + c)), -1);
      end
      check("pre_rst_valid", 32'(bus.o_ob_valid), 32'hF);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.o_ob_valid), 32'h0);
      check("async_rst_idle", 32'(bus.o_idle), 32'h1);
      check("async_rst_drop", 32'(bus.o_drop_count), 32'h0);
      check("async_rst_ready", 32'(bus.o_ib_ready), 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_ob_ready = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(bus.o_ob_valid), 32'h0);
      end

      for (int c = 0; c < 4; c++) check("queue_drained", 32'(exp_q[c].size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
